range_tracker: RTL and testbench

Parametrised successor to the team's range finder: tracks the minimum, maximum, range and sample count of a framed stream of unsigned samples. A run opens with `go`, optionally qualifies each sample with `valid`, and closes with `finish`. The result is selectable by `mode`, and protocol violations are flagged. It sits directly behind the dedicated-input bus in the tile top: `data_in` comes from `ui_in`, `result` drives `uo_out`, and control and status use the bidirectional pins.

---
 rtl/range_tracker_if.sv | 28 ++
 rtl/range_tracker.sv | 128 ++++++++++++
 tb/tb_range_tracker.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/range_tracker_if.sv
// Sample/control bus for range_tracker: the stream source drives the master side
// and the tracker presents results and status on the slave side.
interface range_tracker_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic [WIDTH-1:0]     data_in;
  logic                 valid;
  logic                 go;
  logic                 finish;
  logic [1:0]           mode;
  logic [WIDTH-1:0]     result;
  logic [CNT_WIDTH-1:0] count;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 cnt_sat;

  modport master (
    output data_in, valid, go, finish, mode,
    input  result, count, busy, done, error, cnt_sat
  );

  modport slave (
    input  data_in, valid, go, finish, mode,
    output result, count, busy, done, error, cnt_sat
  );
endinterface

// File: rtl/range_tracker.sv
// Tracks min, max, range and sample count over a framed stream of unsigned samples,
// with go/finish framing, a saturating counter and a sticky protocol-error state.
module range_tracker #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  range_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_min;
  logic [WIDTH-1:0]     r_max;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_sat;
  logic                 r_done;

  logic                 w_start;
  logic                 w_accept;
  logic                 w_done_next;
  logic [WIDTH-1:0]     w_range;
  logic [WIDTH-1:0]     w_count_ext;
  logic [WIDTH-1:0]     w_result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_accept     = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE, ERR: begin
        if (bus.go && !bus.finish) begin
          w_state_next = RUN;
          w_start      = 1'b1;
        end else if (bus.finish) begin
          w_state_next = ERR;
        end
      end
      RUN: begin
        // A go inside a run is a restart violation and discards its sample.
        if (bus.go) begin
          w_state_next = ERR;
        end else begin
          w_accept = bus.valid;
          if (bus.finish) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_min  <= '0;
      r_max  <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_next;
      if (w_start) begin
        r_min <= bus.data_in;
        r_max <= bus.data_in;
        r_cnt <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        r_sat <= 1'b0;
      end else if (w_state_next == ERR) begin
        r_min <= '0;
        r_max <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        if (bus.data_in < r_min) r_min <= bus.data_in;
        if (bus.data_in > r_max) r_max <= bus.data_in;
        if (&r_cnt) begin
          r_sat <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign w_range = r_max - r_min;

  generate
    if (CNT_WIDTH < WIDTH) begin : g_cnt_ext
      assign w_count_ext = {{(WIDTH-CNT_WIDTH){1'b0}}, r_cnt};
    end else begin : g_cnt_trunc
      assign w_count_ext = r_cnt[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    w_result = w_range;
    case (bus.mode)
      2'd0:    w_result = w_range;
      2'd1:    w_result = r_min;
      2'd2:    w_result = r_max;
      default: w_result = w_count_ext;
    endcase
  end

  assign bus.result  = w_result;
  assign bus.count   = r_cnt;
  assign bus.busy    = (r_state == RUN);
  assign bus.done    = r_done;
  assign bus.error   = (r_state == ERR);
  assign bus.cnt_sat = r_sat;

endmodule

// File: tb/tb_range_tracker.sv
// Directed bench for range_tracker: one full-width instance and one with a 2-bit
// counter for saturation, both checked against hand-computed values.
module tb_range_tracker;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  range_tracker_if #(.WIDTH(8), .CNT_WIDTH(8)) a_if ();
  range_tracker_if #(.WIDTH(8), .CNT_WIDTH(2)) b_if ();

  range_tracker #(.WIDTH(8), .CNT_WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  range_tracker #(.WIDTH(8), .CNT_WIDTH(2)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Inputs set before step() are sampled at the next edge; outputs are read 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode_a(input logic [1:0] m);
    a_if.mode = m;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    a_if.data_in = '0; a_if.valid = 0; a_if.go = 0; a_if.finish = 0; a_if.mode = 2'd0;
    b_if.data_in = '0; b_if.valid = 0; b_if.go = 0; b_if.finish = 0; b_if.mode = 2'd3;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_range", a_if.result, 0);
    check("rst_count", a_if.count, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_done", a_if.done, 0);
    check("rst_error", a_if.error, 0);
    check("rst_sat", a_if.cnt_sat, 0);
    set_mode_a(2'd2);
    check("rst_max", a_if.result, 0);

    // Basic run
    a_if.go = 1; a_if.data_in = 8'h20;
    step();
    a_if.go = 0;
    check("go_busy", a_if.busy, 1);
    check("go_count", a_if.count, 1);
    check("go_max", a_if.result, 8'h20);
    a_if.valid = 1;
    a_if.data_in = 8'h05; step();
    a_if.data_in = 8'hF0; step();
    a_if.data_in = 8'h40; step();
    a_if.valid = 0; a_if.finish = 1;
    step();
    a_if.finish = 0;
    check("basic_done", a_if.done, 1);
    check("basic_busy", a_if.busy, 0);
    set_mode_a(2'd0); check("basic_range", a_if.result, 8'hEB);
    set_mode_a(2'd1); check("basic_min", a_if.result, 8'h05);
    set_mode_a(2'd2); check("basic_max", a_if.result, 8'hF0);
    set_mode_a(2'd3); check("basic_cnt", a_if.result, 8'h04);
    step();
    check("basic_done_fall", a_if.done, 0);
    check("basic_hold", a_if.result, 8'h04);

    // Valid gaps, finish carrying a sample
    a_if.go = 1; a_if.data_in = 8'h10;
    step();
    a_if.go = 0; a_if.valid = 0; a_if.data_in = 8'hFF;
    step();
    step();
    a_if.finish = 1; a_if.valid = 1; a_if.data_in = 8'h08;
    step();
    a_if.finish = 0; a_if.valid = 0;
    check("gap_done", a_if.done, 1);
    check("gap_count", a_if.count, 2);
    set_mode_a(2'd1); check("gap_min", a_if.result, 8'h08);
    set_mode_a(2'd2); check("gap_max", a_if.result, 8'h10);

    // Back-to-back: go in the done cycle
    a_if.go = 1; a_if.data_in = 8'h77;
    step();
    a_if.go = 0;
    check("b2b_done", a_if.done, 0);
    check("b2b_busy", a_if.busy, 1);
    check("b2b_count", a_if.count, 1);
    set_mode_a(2'd1); check("b2b_min", a_if.result, 8'h77);
    a_if.finish = 1;
    step();
    a_if.finish = 0;
    check("b2b_fin_done", a_if.done, 1);
    step();

    // Errors
    a_if.finish = 1;
    step();
    a_if.finish = 0;
    check("idle_fin_err", a_if.error, 1);
    set_mode_a(2'd0); check("idle_fin_res", a_if.result, 0);
    check("idle_fin_cnt", a_if.count, 0);
    a_if.go = 1; a_if.finish = 1; a_if.data_in = 8'h44;
    step();
    a_if.go = 0; a_if.finish = 0;
    check("gofin_err", a_if.error, 1);
    check("gofin_busy", a_if.busy, 0);
    a_if.go = 1; a_if.data_in = 8'h33;
    step();
    check("legal_go_err", a_if.error, 0);
    check("legal_go_cnt", a_if.count, 1);
    a_if.data_in = 8'h99;
    step();
    a_if.go = 0;
    check("restart_err", a_if.error, 1);
    check("restart_busy", a_if.busy, 0);
    check("restart_done", a_if.done, 0);
    check("restart_cnt", a_if.count, 0);
    a_if.go = 1; a_if.data_in = 8'h33;
    step();
    a_if.go = 0;
    check("recover_err", a_if.error, 0);
    check("recover_cnt", a_if.count, 1);
    set_mode_a(2'd2); check("recover_max", a_if.result, 8'h33);
    a_if.finish = 1;
    step();
    a_if.finish = 0;
    check("recover_done", a_if.done, 1);

    // Saturation on the 2-bit counter instance
    b_if.go = 1; b_if.data_in = 8'h01;
    step();
    b_if.go = 0; b_if.valid = 1;
    b_if.data_in = 8'h02; step();
    b_if.data_in = 8'h03; step();
    check("sat_cnt3", b_if.count, 3);
    check("sat_not_yet", b_if.cnt_sat, 0);
    b_if.data_in = 8'h04; step();
    check("sat_cnt_hold", b_if.count, 3);
    check("sat_set", b_if.cnt_sat, 1);
    b_if.valid = 0; b_if.finish = 1;
    step();
    b_if.finish = 0;
    check("sat_done", b_if.done, 1);
    check("sat_after_fin", b_if.cnt_sat, 1);
    check("sat_mode3", b_if.result, 8'h03);
    b_if.go = 1; b_if.data_in = 8'h09;
    step();
    b_if.go = 0;
    check("sat_cleared", b_if.cnt_sat, 0);
    check("sat_new_cnt", b_if.count, 1);

    // Reset mid-run
    a_if.go = 1; a_if.data_in = 8'h50;
    step();
    a_if.go = 0; a_if.valid = 1; a_if.data_in = 8'h60;
    step();
    a_if.valid = 0;
    check("pre_rst_busy", a_if.busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_busy", a_if.busy, 0);
    check("mid_rst_cnt", a_if.count, 0);
    set_mode_a(2'd2); check("mid_rst_max", a_if.result, 0);
    set_mode_a(2'd1); check("mid_rst_min", a_if.result, 0);
    check("mid_rst_err", a_if.error, 0);
    check("mid_rst_sat_b", b_if.cnt_sat, 0);
    a_if.finish = 1;
    step();
    a_if.finish = 0;
    check("post_rst_fin_err", a_if.error, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
